// File: rtl/char_rom_arbiter.sv
// -----------------------------------------------------------------------------
// char_rom_arbiter
//
// Lets the host and guest character draw engines share one character-image
// ROM (432 x 432 pixels, 12-bit RGB). One read is accepted per clock through
// a req/gnt handshake. The arbiter drives a registered ROM port and sends the
// pipelined read data back to the engine that issued the read, at a fixed
// latency of ROM_LATENCY + 2 cycles after acceptance.
//
// Build option:
//   CHAR_ARB_FIXED_PRIO_EN  defined   -> the host always wins a conflict and
//                                        there is no last_win register
//                           undefined -> round robin using last_win (default)
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   host_req / host_addr       host read request and word address
//   host_gnt                   combinational grant; accepted when req && gnt
//   host_rvalid / host_rdata   one-cycle return pulse and returned pixel
//   guest_*                    the same set of ports for the guest engine
//   rom_en / rom_addr          registered ROM read strobe and address
//   rom_rdata                  ROM data, valid ROM_LATENCY cycles after rom_en
// -----------------------------------------------------------------------------
module char_rom_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned ROM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  host_req,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,

    input  logic                  guest_req,
    input  logic [ADDR_WIDTH-1:0] guest_addr,
    output logic                  guest_gnt,
    output logic                  guest_rvalid,
    output logic [DATA_WIDTH-1:0] guest_rdata,

    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata
);

    localparam int unsigned CHAR_LENGTH = 432;
    localparam int unsigned CHAR_HEIGHT = 432;
    localparam int unsigned ROM_WORDS   = CHAR_LENGTH * CHAR_HEIGHT;

    localparam logic OWNER_HOST  = 1'b0;
    localparam logic OWNER_GUEST = 1'b1;

    // One bit wider than the address so the word count always fits.
    localparam logic [ADDR_WIDTH:0] ROM_LIMIT = (ADDR_WIDTH + 1)'(ROM_WORDS);

    logic                  accept;
    logic                  acc_owner;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_oob;

    // ------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------
`ifdef CHAR_ARB_FIXED_PRIO_EN
    always_comb begin
        host_gnt  = host_req;
        guest_gnt = guest_req & ~host_req;
    end
`else
    logic last_win_q;

    always_comb begin
        host_gnt  = 1'b0;
        guest_gnt = 1'b0;
        if (host_req && guest_req) begin
            // On a conflict the side that did not win last time gets the grant.
            host_gnt  = (last_win_q == OWNER_GUEST);
            guest_gnt = (last_win_q == OWNER_HOST);
        end else begin
            host_gnt  = host_req;
            guest_gnt = guest_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_win_q <= OWNER_GUEST;
        end else if (accept) begin
            last_win_q <= acc_owner;
        end
    end
`endif

    // A grant is only raised together with its own request.
    assign accept    = host_gnt | guest_gnt;
    assign acc_owner = guest_gnt ? OWNER_GUEST : OWNER_HOST;
    assign acc_addr  = guest_gnt ? guest_addr : host_addr;
    assign acc_oob   = ({1'b0, acc_addr} >= ROM_LIMIT);

    // ------------------------------------------------------------------
    // ROM port
    // ------------------------------------------------------------------
    logic                  rom_en_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            // An out-of-range read is accepted but never reaches the ROM.
            rom_en_q <= accept & ~acc_oob;
            if (accept && !acc_oob) begin
                rom_addr_q <= acc_addr;
            end
        end
    end

    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;

    // ------------------------------------------------------------------
    // Tag pipeline: stage k is valid during accept cycle + 1 + k, so the tail
    // (stage ROM_LATENCY) lines up with rom_rdata for the same read.
    // ------------------------------------------------------------------
    logic [ROM_LATENCY:0] tag_valid_q;
    logic [ROM_LATENCY:0] tag_owner_q;
    logic [ROM_LATENCY:0] tag_oob_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_q <= '0;
            tag_owner_q <= '0;
            tag_oob_q   <= '0;
        end else begin
            tag_valid_q <= {tag_valid_q[ROM_LATENCY-1:0], accept};
            tag_owner_q <= {tag_owner_q[ROM_LATENCY-1:0], acc_owner};
            tag_oob_q   <= {tag_oob_q[ROM_LATENCY-1:0], acc_oob};
        end
    end

    logic                  tail_valid;
    logic                  tail_owner;
    logic [DATA_WIDTH-1:0] tail_data;

    assign tail_valid = tag_valid_q[ROM_LATENCY];
    assign tail_owner = tag_owner_q[ROM_LATENCY];
    assign tail_data  = tag_oob_q[ROM_LATENCY] ? '0 : rom_rdata;

    // ------------------------------------------------------------------
    // Return path: only the owner's data register is loaded, so the other
    // engine's rdata keeps its last value.
    // ------------------------------------------------------------------
    logic                  host_rvalid_q;
    logic                  guest_rvalid_q;
    logic [DATA_WIDTH-1:0] host_rdata_q;
    logic [DATA_WIDTH-1:0] guest_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rvalid_q  <= 1'b0;
            guest_rvalid_q <= 1'b0;
            host_rdata_q   <= '0;
            guest_rdata_q  <= '0;
        end else begin
            host_rvalid_q  <= tail_valid && (tail_owner == OWNER_HOST);
            guest_rvalid_q <= tail_valid && (tail_owner == OWNER_GUEST);
            if (tail_valid && (tail_owner == OWNER_HOST)) begin
                host_rdata_q <= tail_data;
            end
            if (tail_valid && (tail_owner == OWNER_GUEST)) begin
                guest_rdata_q <= tail_data;
            end
        end
    end

    assign host_rvalid  = host_rvalid_q;
    assign guest_rvalid = guest_rvalid_q;
    assign host_rdata   = host_rdata_q;
    assign guest_rdata  = guest_rdata_q;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_char_rom_arbiter
//
// Two arbiters share the same request stimulus: index 0 uses ROM_LATENCY=2,
// index 1 uses ROM_LATENCY=1. Each has its own behavioural ROM. The driver
// checks grants and the ROM port, then pushes the expected response for each
// accepted read into that instance's queue. A separate monitor pops and
// compares whenever an rvalid appears, or when an expected response is late.
// -----------------------------------------------------------------------------
module tb_char_rom_arbiter;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 12;

    typedef struct packed {
        logic          owner;   // 0 host, 1 guest
        logic [DW-1:0] data;
        logic [31:0]   due;     // cycle in which rvalid must be seen
    } exp_t;

    logic          clk;
    logic          rst;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic          guest_req;
    logic [AW-1:0] guest_addr;

    logic [1:0]    host_gnt;
    logic [1:0]    guest_gnt;
    logic [1:0]    host_rvalid;
    logic [1:0]    guest_rvalid;
    logic [1:0]    rom_en;
    logic [DW-1:0] host_rdata  [2];
    logic [DW-1:0] guest_rdata [2];
    logic [AW-1:0] rom_addr    [2];
    logic [DW-1:0] rom_rdata   [2];
    logic [DW-1:0] rom_pipe    [2][2];

    exp_t          sb_q [2][$];
    logic [DW-1:0] exp_hd [2];
    logic [DW-1:0] exp_gd [2];

    logic [31:0]   cyc;
    int            n_checks;
    int            n_fail;

    logic          last_guest;
    logic          pend_en;
    logic [AW-1:0] pend_addr;

    char_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2)) u_dut_l2 (
        .clk          (clk),
        .rst          (rst),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_gnt     (host_gnt[0]),
        .host_rvalid  (host_rvalid[0]),
        .host_rdata   (host_rdata[0]),
        .guest_req    (guest_req),
        .guest_addr   (guest_addr),
        .guest_gnt    (guest_gnt[0]),
        .guest_rvalid (guest_rvalid[0]),
        .guest_rdata  (guest_rdata[0]),
        .rom_en       (rom_en[0]),
        .rom_addr     (rom_addr[0]),
        .rom_rdata    (rom_rdata[0])
    );

    char_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) u_dut_l1 (
        .clk          (clk),
        .rst          (rst),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_gnt     (host_gnt[1]),
        .host_rvalid  (host_rvalid[1]),
        .host_rdata   (host_rdata[1]),
        .guest_req    (guest_req),
        .guest_addr   (guest_addr),
        .guest_gnt    (guest_gnt[1]),
        .guest_rvalid (guest_rvalid[1]),
        .guest_rdata  (guest_rdata[1]),
        .rom_en       (rom_en[1]),
        .rom_addr     (rom_addr[1]),
        .rom_rdata    (rom_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // ROM contents; word 0 is non-zero so an oob zero cannot pass by accident.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[11:0] ^ 12'hA5C ^ {6'b0, a[17:12]};
    endfunction

    function automatic logic [31:0] lat_of(input int d);
        return (d == 0) ? 32'd2 : 32'd1;
    endfunction

    // Behavioural ROMs; 12'hBAD shows up whenever nothing was read.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rom_pipe[d][1] <= rom_pipe[d][0];
            rom_pipe[d][0] <= rom_en[d] ? rom_word(rom_addr[d]) : 12'hBAD;
        end
    end
    assign rom_rdata[0] = rom_pipe[0][1];
    assign rom_rdata[1] = rom_pipe[1][0];

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @cyc %0d: got 0x%0h, want 0x%0h", name, d, cyc, act, exp);
        end
    endtask

    // Monitor: consumes the scoreboard whenever a response appears or is due.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            if (host_rvalid[d] === 1'b1 || guest_rvalid[d] === 1'b1) begin
                chk("rvalid_exclusive", d, 32'(host_rvalid[d] & guest_rvalid[d]), 32'd0);
                if (sb_q[d].size() == 0) begin
                    chk("spurious_rvalid", d, 32'd1, 32'd0);
                end else begin
                    e = sb_q[d].pop_front();
                    chk("rvalid_cycle", d, cyc, e.due);
                    chk("rvalid_owner", d, 32'(guest_rvalid[d]), 32'(e.owner));
                    if (e.owner) begin
                        chk("guest_rdata", d, 32'(guest_rdata[d]), 32'(e.data));
                        chk("host_rdata_hold", d, 32'(host_rdata[d]), 32'(exp_hd[d]));
                        exp_gd[d] = e.data;
                    end else begin
                        chk("host_rdata", d, 32'(host_rdata[d]), 32'(e.data));
                        chk("guest_rdata_hold", d, 32'(guest_rdata[d]), 32'(exp_gd[d]));
                        exp_hd[d] = e.data;
                    end
                end
            end else if (sb_q[d].size() != 0 && sb_q[d][0].due <= cyc) begin
                chk("missing_rvalid", d, 32'd0, 32'd1);
                e = sb_q[d].pop_front();
            end
        end
    end

    // One clock of stimulus: check the ROM port for the previous accept, apply
    // the requests, check the grants and record any accepted read.
    task automatic step(input logic hr, input logic [AW-1:0] ha,
                        input logic gr, input logic [AW-1:0] ga);
        logic          eh, eg, oob;
        logic [AW-1:0] a;
        exp_t          e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rom_en", d, 32'(rom_en[d]), 32'(pend_en));
            if (pend_en) chk("rom_addr", d, 32'(rom_addr[d]), 32'(pend_addr));
        end
        host_req   = hr;
        host_addr  = ha;
        guest_req  = gr;
        guest_addr = ga;
        #1;
`ifdef CHAR_ARB_FIXED_PRIO_EN
        eh = hr;
        eg = gr && !hr;
`else
        if (hr && gr) begin
            eh = last_guest;
            eg = !last_guest;
        end else begin
            eh = hr;
            eg = gr;
        end
`endif
        for (int d = 0; d < 2; d++) begin
            chk("host_gnt", d, 32'(host_gnt[d]), 32'(eh));
            chk("guest_gnt", d, 32'(guest_gnt[d]), 32'(eg));
        end
        pend_en = 1'b0;
        if (eh || eg) begin
            a         = eg ? ga : ha;
            oob       = (a >= 18'd186624);
            pend_en   = !oob;
            pend_addr = a;
            last_guest = eg;
            for (int d = 0; d < 2; d++) begin
                e.owner = eg;
                e.data  = oob ? 12'h000 : rom_word(a);
                e.due   = cyc + 32'd2 + lat_of(d);
                sb_q[d].push_back(e);
            end
        end
    endtask

    task automatic check_reset_values();
        for (int d = 0; d < 2; d++) begin
            chk("rst_host_gnt", d, 32'(host_gnt[d]), 32'd0);
            chk("rst_guest_gnt", d, 32'(guest_gnt[d]), 32'd0);
            chk("rst_rom_en", d, 32'(rom_en[d]), 32'd0);
            chk("rst_rom_addr", d, 32'(rom_addr[d]), 32'd0);
            chk("rst_host_rvalid", d, 32'(host_rvalid[d]), 32'd0);
            chk("rst_guest_rvalid", d, 32'(guest_rvalid[d]), 32'd0);
            chk("rst_host_rdata", d, 32'(host_rdata[d]), 32'd0);
            chk("rst_guest_rdata", d, 32'(guest_rdata[d]), 32'd0);
        end
    endtask

    task automatic clear_model();
        last_guest = 1'b1;
        pend_en    = 1'b0;
        pend_addr  = '0;
        for (int d = 0; d < 2; d++) begin
            sb_q[d].delete();
            exp_hd[d] = '0;
            exp_gd[d] = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc        = '0;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        host_req   = 1'b0;
        host_addr  = '0;
        guest_req  = 1'b0;
        guest_addr = '0;
        clear_model();

        repeat (3) @(negedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // Single host read of word 0.
        step(1'b1, 18'd0, 1'b0, 18'd0);
        repeat (5) step(1'b0, 18'd0, 1'b0, 18'd0);

        // Last in-range word, then first out-of-range word.
        step(1'b1, 18'd186623, 1'b0, 18'd0);
        step(1'b1, 18'd186624, 1'b0, 18'd0);
        repeat (5) step(1'b0, 18'd0, 1'b0, 18'd0);

        // Eight back-to-back guest reads; leaves last_win = guest.
        for (int i = 0; i < 8; i++) step(1'b0, 18'd0, 1'b1, 18'(i));
        repeat (5) step(1'b0, 18'd0, 1'b0, 18'd0);

        // Both requesting: H,G,H,G (H,H,H,H with fixed priority).
        repeat (4) step(1'b1, 18'd10, 1'b1, 18'd20);
        repeat (5) step(1'b0, 18'd0, 1'b0, 18'd0);

        // Alternating single requesters: tags must follow the owner.
        step(1'b1, 18'd50, 1'b0, 18'd0);
        step(1'b0, 18'd0, 1'b1, 18'd51);
        step(1'b1, 18'd52, 1'b0, 18'd0);
        step(1'b0, 18'd0, 1'b1, 18'd53);
        step(1'b1, 18'd432, 1'b1, 18'd433);
        repeat (5) step(1'b0, 18'd0, 1'b0, 18'd0);

        // Reset two cycles after three host accepts drops what is in flight.
        step(1'b1, 18'd100, 1'b0, 18'd0);
        step(1'b1, 18'd101, 1'b0, 18'd0);
        step(1'b1, 18'd102, 1'b0, 18'd0);
        step(1'b0, 18'd0, 1'b0, 18'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) step(1'b0, 18'd0, 1'b0, 18'd0);

        // After reset the host wins the first conflict again, at word 0.
        step(1'b1, 18'd0, 1'b1, 18'd5);
        step(1'b1, 18'd0, 1'b1, 18'd5);
        repeat (8) step(1'b0, 18'd0, 1'b0, 18'd0);

        for (int d = 0; d < 2; d++) chk("drain", d, 32'(sb_q[d].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
